// File: rtl/snn_pkg.sv
// ============================================================================
// Module : snn_pkg
// Brief  : Shared state encoding for the SNN run controllers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snn_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SNN_IDLE  = 2'd0,
        SNN_CLEAR = 2'd1,
        SNN_RUN   = 2'd2,
        SNN_STORE = 2'd3
    } snn_state_e;

    localparam logic [STATE_W-1:0] ST_IDLE  = SNN_IDLE;
    localparam logic [STATE_W-1:0] ST_CLEAR = SNN_CLEAR;
    localparam logic [STATE_W-1:0] ST_RUN   = SNN_RUN;
    localparam logic [STATE_W-1:0] ST_STORE = SNN_STORE;

endpackage

`default_nettype wire

// File: rtl/snn_up_counter.sv
// ============================================================================
// Module : snn_up_counter
// Brief  : Up counter with synchronous clear, enable and terminal-value flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snn_up_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so a phase restart never sees a stale increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == max_val);

endmodule

`default_nettype wire

// File: rtl/snn_core_sequencer.sv
// ============================================================================
// Module : snn_core_sequencer
// Brief  : Inference run controller: clear, N handshaked timesteps, store sweep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snn_core_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_OUTPUTS = 10,
    parameter int SIM_TIME_W  = 16,
    parameter int OUT_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  network_start,
    input  logic                  abort,
    input  logic [SIM_TIME_W-1:0] cfg_sim_time,
    input  logic                  cfg_continuous,
    input  logic                  network_step_done,
    output logic                  network_rst,
    output logic                  network_en,
    output logic [SIM_TIME_W-1:0] sim_time,
    output logic [OUT_W-1:0]      output_idx,
    output logic                  output_we,
    output logic                  busy,
    output logic                  done,
    output logic                  run_done,
    output logic                  aborted
);

    localparam logic [OUT_W-1:0] c_last_idx = OUT_W'(NUM_OUTPUTS - 1);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_next;
    logic [SIM_TIME_W-1:0] r_tsteps;
    logic                  r_cont;
    logic                  r_run_done;
    logic                  r_aborted;

    logic                  w_idle;
    logic                  w_clear;
    logic                  w_run;
    logic                  w_store;
    logic                  w_sim_last;
    logic                  w_idx_last;
    logic                  w_last_step;
    logic [SIM_TIME_W-1:0] w_cfg_tsteps;
    logic [SIM_TIME_W-1:0] w_tsteps_max;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_clear = (r_state == ST_CLEAR);
    assign w_run   = (r_state == ST_RUN);
    assign w_store = (r_state == ST_STORE);

    assign w_cfg_tsteps = (cfg_sim_time == '0) ? SIM_TIME_W'(1) : cfg_sim_time;
    assign w_tsteps_max = r_tsteps - SIM_TIME_W'(1);
    assign w_last_step  = w_run && network_step_done && w_sim_last;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (network_start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (network_step_done && w_sim_last)
                    w_next = ST_STORE;
            end
            ST_STORE: begin
                if (abort)
                    w_next = ST_IDLE;
                else if (w_idx_last)
                    w_next = r_cont ? ST_CLEAR : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tsteps   <= '0;
            r_cont     <= 1'b0;
            r_run_done <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_run_done <= w_store && w_idx_last && !abort;
            r_aborted  <= abort && !w_idle;
            // Config is frozen for the whole run, including continuous restarts.
            if (w_idle && network_start) begin
                r_tsteps <= w_cfg_tsteps;
                r_cont   <= cfg_continuous;
            end
        end
    end

    snn_up_counter #(
        .WIDTH   (SIM_TIME_W)
    ) u_sim_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clear),
        .en      (w_run && network_step_done && !w_sim_last && !abort),
        .max_val (w_tsteps_max),
        .count   (sim_time),
        .at_max  (w_sim_last)
    );

    snn_up_counter #(
        .WIDTH   (OUT_W)
    ) u_idx_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_last_step && !abort),
        .en      (w_store && !w_idx_last && !abort),
        .max_val (c_last_idx),
        .count   (output_idx),
        .at_max  (w_idx_last)
    );

    assign network_rst = w_clear && !abort;
    assign network_en  = w_run && !network_step_done && !abort;
    assign output_we   = w_store && !abort;
    assign done        = w_idle;
    assign busy        = !w_idle;
    assign run_done    = r_run_done;
    assign aborted     = r_aborted;

endmodule

`default_nettype wire
